// File: rtl/edge_filter_sequencer_if.sv
// ---------------------------------------------------------------------------
// edge_filter_sequencer_if
//   Handshake bundle for the edge filter sequencer.
//   Upstream row stream : in_valid, in_ready, in_row
//   Downstream result   : out_valid, out_ready, out_data
//   master : the producer of rows and consumer of results (testbench / IDCT side)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface edge_filter_sequencer_if #(
  parameter int ROW_W = 64,
  parameter int RES_W = 64
);

  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_row;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_row,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_row,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/edge_filter_sequencer.sv
// ---------------------------------------------------------------------------
// edge_filter_sequencer
//   Collects an 8x8 pixel block from a row stream, freezes it in front of the
//   free-running edge filter for its pipeline latency, captures the filter
//   result and offers it downstream over valid/ready.  Rows of the next block
//   may be prefilled while the result waits, except the last row, so a new
//   capture can never overwrite an unconsumed result.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-high
//   flush        synchronous abort of the current block (wins over handshakes)
//   bus          handshake bundle (slave view): in_valid/in_ready/in_row,
//                out_valid/out_ready/out_data
//   filt_block   block buffer to the filter, row k at [k*ROW_W +: ROW_W]
//   filt_stable  high while filt_block is complete and frozen
//   filt_result  filter output word
//   busy         high when not idle (state != FILL or rows pending)
//   blk_count    completed output handshakes, wraps silently
//
// state  | meaning
// S_FILL | accepting rows of a block; last row moves to S_WAIT
// S_WAIT | block frozen, counting filter latency, then capture result
// S_OUT  | result offered downstream; rows 0..ROWS-2 may be prefilled
// ---------------------------------------------------------------------------
module edge_filter_sequencer #(
  parameter int ROWS       = 8,
  parameter int ROW_W      = 64,
  parameter int FILTER_LAT = 3,
  parameter int RES_W      = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  edge_filter_sequencer_if.slave bus,
  output logic [ROWS*ROW_W-1:0] filt_block,
  output logic                  filt_stable,
  input  logic [RES_W-1:0]      filt_result,
  output logic                  busy,
  output logic [CNT_W-1:0]      blk_count
);

  localparam int ROW_CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LAT_CW = (FILTER_LAT > 0) ? $clog2(FILTER_LAT + 1) : 1;
  localparam logic [ROW_CW-1:0] LAST_ROW = ROW_CW'(ROWS - 1);
  localparam logic [LAT_CW-1:0] LAT_DONE = LAT_CW'(FILTER_LAT);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t              state;
  logic [ROW_CW-1:0]   row_cnt;
  logic [LAT_CW-1:0]   lat_cnt;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [RES_W-1:0]    out_data_q;
  logic                filt_stable_q;
  logic                busy_q;

  logic                in_fire;
  logic                out_fire;
  logic [ROW_CW-1:0]   row_cnt_inc;

  assign in_fire     = bus.in_valid & in_ready_q;
  assign out_fire    = out_valid_q & bus.out_ready;
  assign row_cnt_inc = row_cnt + ROW_CW'(1);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign filt_stable   = filt_stable_q;
  assign busy          = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_FILL;
      row_cnt       <= '0;
      lat_cnt       <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      filt_stable_q <= 1'b0;
      busy_q        <= 1'b0;
      filt_block    <= '0;
      blk_count     <= '0;
    end else if (flush) begin
      state         <= S_FILL;
      row_cnt       <= '0;
      lat_cnt       <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      filt_stable_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_fire) begin
            filt_block[int'(row_cnt)*ROW_W +: ROW_W] <= bus.in_row;
            busy_q <= 1'b1;
            if (row_cnt == LAST_ROW) begin
              row_cnt       <= '0;
              lat_cnt       <= '0;
              in_ready_q    <= 1'b0;
              filt_stable_q <= 1'b1;
              state         <= S_WAIT;
            end else begin
              row_cnt <= row_cnt_inc;
            end
          end
        end

        S_WAIT: begin
          lat_cnt <= lat_cnt + LAT_CW'(1);
          if (lat_cnt == LAT_DONE) begin
            out_data_q    <= filt_result;
            out_valid_q   <= 1'b1;
            filt_stable_q <= 1'b0;
            // row_cnt is 0 here, so prefill is allowed unless a block is one row
            in_ready_q    <= (LAST_ROW != '0);
            state         <= S_OUT;
          end
        end

        S_OUT: begin
          if (in_fire) begin
            filt_block[int'(row_cnt)*ROW_W +: ROW_W] <= bus.in_row;
            row_cnt <= row_cnt_inc;
          end
          if (out_fire) begin
            out_valid_q <= 1'b0;
            blk_count   <= blk_count + CNT_W'(1);
            in_ready_q  <= 1'b1;
            busy_q      <= in_fire || (row_cnt != '0);
            state       <= S_FILL;
          end else if (in_fire) begin
            // the last row must wait until the result has been taken
            in_ready_q <= (row_cnt_inc != LAST_ROW);
          end
        end

        default: begin
          state <= S_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_filter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_edge_filter_sequencer
//   Directed bench for edge_filter_sequencer.  The DUT is built with a 4-bit
//   block counter so counter wrap is reached in a handful of blocks.
// ---------------------------------------------------------------------------
module tb_edge_filter_sequencer;

  localparam int ROWS  = 8;
  localparam int ROW_W = 64;
  localparam int RES_W = 64;
  localparam int CNT_W = 4;

  logic                  clk;
  logic                  reset;
  logic                  flush;
  logic [ROWS*ROW_W-1:0] filt_block;
  logic                  filt_stable;
  logic [RES_W-1:0]      filt_result;
  logic                  busy;
  logic [CNT_W-1:0]      blk_count;

  int checks;
  int errors;

  edge_filter_sequencer_if #(.ROW_W(ROW_W), .RES_W(RES_W)) bus ();

  edge_filter_sequencer #(
    .ROWS(ROWS), .ROW_W(ROW_W), .FILTER_LAT(3), .RES_W(RES_W), .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus),
    .filt_block  (filt_block),
    .filt_stable (filt_stable),
    .filt_result (filt_result),
    .busy        (busy),
    .blk_count   (blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer one row and hold it until accepted (bounded)
  task automatic send_row(input logic [63:0] row, output bit ok);
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_row   = row;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_capture(output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || filt_stable !== 1'b0 ||
        busy !== 1'b0 || blk_count !== 4'd0 || bus.out_data !== 64'd0 || filt_block !== '0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b stable=%b busy=%b blk=%0d", bus.in_ready,
               bus.out_valid, filt_stable, busy, blk_count);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_idle: in_ready=%b busy=%b want 1 0", bus.in_ready, busy);
    end
  endtask

  task automatic test_basic_block();
    bit ok;
    int edges;
    int stable_cnt;
    logic [63:0] row;
    filt_result   = 64'hA5A5_A5A5_A5A5_A5A5;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      row = 64'h0101_0101_0101_0101 * (k + 1);
      send_row(row, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL basic_accept row %0d: not accepted", k);
      end
    end
    checks++;
    if (filt_block[0 +: 64] !== 64'h0101_0101_0101_0101 ||
        filt_block[7*64 +: 64] !== 64'h0808_0808_0808_0808) begin
      errors++;
      $display("FAIL basic_rows: row0=%h row7=%h", filt_block[0 +: 64], filt_block[7*64 +: 64]);
    end
    stable_cnt = 0;
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      if (filt_stable) stable_cnt++;
      tick();
      edges++;
    end
    checks++;
    if (edges !== 4 || stable_cnt !== 4) begin
      errors++;
      $display("FAIL basic_latency: edges=%0d stable=%0d want 4 4", edges, stable_cnt);
    end
    checks++;
    if (bus.out_data !== 64'hA5A5_A5A5_A5A5_A5A5 || filt_stable !== 1'b0) begin
      errors++;
      $display("FAIL basic_capture: data=%h stable=%b", bus.out_data, filt_stable);
    end
    tick();
    checks++;
    if (blk_count !== 4'd1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_handshake: blk=%0d out_valid=%b busy=%b want 1 0 0", blk_count,
               bus.out_valid, busy);
    end
  endtask

  task automatic test_backpressure_prefill();
    bit ok;
    int edges;
    int acc;
    bus.out_ready = 1'b0;
    filt_result   = 64'h1122_3344_5566_7788;
    for (int k = 0; k < 8; k++) begin
      send_row(64'h1000 + 64'(k), ok);
    end
    wait_capture(edges);
    checks++;
    if (edges !== 4 || bus.out_data !== 64'h1122_3344_5566_7788) begin
      errors++;
      $display("FAIL bp_capture: edges=%0d data=%h", edges, bus.out_data);
    end
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_row   = 64'h2000 + 64'(acc);
      if (i == 2) filt_result = 64'hDEAD_BEEF_0000_0000;
      if (bus.in_ready) acc++;
      tick();
    end
    checks++;
    if (acc !== 7 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
        bus.out_data !== 64'h1122_3344_5566_7788) begin
      errors++;
      $display("FAIL bp_prefill: accepted=%0d in_ready=%b out_valid=%b data=%h want 7 0 1 1122334455667788",
               acc, bus.in_ready, bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || blk_count !== 4'd2 || filt_stable !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b blk=%0d stable=%b", bus.out_valid,
               bus.in_ready, blk_count, filt_stable);
    end
    bus.out_ready = 1'b0;
    filt_result   = 64'h0F0E_0D0C_0B0A_0908;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (filt_stable !== 1'b1 || bus.in_ready !== 1'b0 || filt_block[0 +: 64] !== 64'h2000 ||
        filt_block[6*64 +: 64] !== 64'h2006 || filt_block[7*64 +: 64] !== 64'h2007) begin
      errors++;
      $display("FAIL bp_eighth_row: stable=%b in_ready=%b row0=%h row6=%h row7=%h", filt_stable,
               bus.in_ready, filt_block[0 +: 64], filt_block[6*64 +: 64], filt_block[7*64 +: 64]);
    end
    wait_capture(edges);
    checks++;
    if (edges !== 4 || bus.out_data !== 64'h0F0E_0D0C_0B0A_0908) begin
      errors++;
      $display("FAIL bp_second_capture: edges=%0d data=%h", edges, bus.out_data);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int k = 0; k < 3; k++) begin
      send_row(64'h3000 + 64'(k), ok);
    end
    bus.in_valid  = 1'b1;
    bus.in_row    = 64'h3003;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (filt_block[3*64 +: 64] !== 64'h3003 || blk_count !== 4'd3 || bus.out_valid !== 1'b0 ||
        bus.in_ready !== 1'b1 || busy !== 1'b1 || bus.out_data !== 64'h0F0E_0D0C_0B0A_0908) begin
      errors++;
      $display("FAIL same_cycle: row3=%h blk=%0d out_valid=%b in_ready=%b busy=%b", filt_block[3*64 +: 64],
               blk_count, bus.out_valid, bus.in_ready, busy);
    end
    for (int k = 4; k < 7; k++) begin
      send_row(64'h3000 + 64'(k), ok);
    end
    checks++;
    if (filt_stable !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_rowcnt: stable=%b after 7 rows want 0", filt_stable);
    end
    send_row(64'h3007, ok);
    checks++;
    if (filt_stable !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_wait: stable=%b after 8 rows want 1", filt_stable);
    end
  endtask

  task automatic test_flush();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (filt_stable !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0 ||
        blk_count !== 4'd3 || bus.out_data !== 64'h0F0E_0D0C_0B0A_0908) begin
      errors++;
      $display("FAIL flush_state: stable=%b out_valid=%b in_ready=%b busy=%b blk=%0d data=%h",
               filt_stable, bus.out_valid, bus.in_ready, busy, blk_count, bus.out_data);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_capture: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int edges;
    for (int k = 0; k < 5; k++) begin
      send_row(64'h5000 + 64'(k), ok);
    end
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL partial_busy: busy=%b in_ready=%b want 1 1", busy, bus.in_ready);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1 || filt_block !== '0 || blk_count !== 4'd0 ||
        bus.out_data !== 64'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b in_ready=%b blk=%0d data=%h", busy, bus.in_ready,
               blk_count, bus.out_data);
    end
    #1;
    reset = 1'b0;
    filt_result   = 64'h7777_0000_7777_0000;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      send_row(64'h6000 + 64'(k), ok);
    end
    checks++;
    if (filt_stable !== 1'b0) begin
      errors++;
      $display("FAIL reset_fresh_rows: stable=%b after 7 rows want 0", filt_stable);
    end
    send_row(64'h6007, ok);
    wait_capture(edges);
    checks++;
    if (edges !== 4 || bus.out_data !== 64'h7777_0000_7777_0000) begin
      errors++;
      $display("FAIL reset_block_capture: edges=%0d data=%h", edges, bus.out_data);
    end
    tick();
    checks++;
    if (blk_count !== 4'd1) begin
      errors++;
      $display("FAIL reset_block_count: blk=%0d want 1", blk_count);
    end
  endtask

  task automatic test_count_wrap();
    bit ok;
    int edges;
    bus.out_ready = 1'b1;
    for (int b = 0; b < 15; b++) begin
      filt_result = 64'hC0DE_0000_0000_0000 + 64'(b);
      for (int k = 0; k < 8; k++) begin
        send_row(64'(b * 16 + k), ok);
      end
      wait_capture(edges);
      checks++;
      if (edges !== 4 || bus.out_data !== 64'hC0DE_0000_0000_0000 + 64'(b)) begin
        errors++;
        $display("FAIL wrap_block %0d: edges=%0d data=%h", b, edges, bus.out_data);
      end
      tick();
      if (b == 13) begin
        checks++;
        if (blk_count !== 4'd15) begin
          errors++;
          $display("FAIL wrap_max: blk=%0d want 15", blk_count);
        end
      end
    end
    checks++;
    if (blk_count !== 4'd0) begin
      errors++;
      $display("FAIL wrap_zero: blk=%0d want 0", blk_count);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.out_ready = 1'b0;
    filt_result   = '0;
    test_reset();
    test_basic_block();
    test_backpressure_prefill();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
